imm_gen_stage: RTL and testbench

Pipelined immediate-generation stage between fetch and execute in the RISC-V core. It accepts one instruction per valid/ready transfer and classifies the opcode into an extender op. It drives the extender sub-module with the sliced immediate fields, then registers the immediate, the op, the PC and the PC-relative target for the execute stage. It also provides back-pressure and a synchronous flush for branch redirects.

---
 rtl/imm_gen_pkg.sv | 40 ++++
 rtl/imm_gen_ext.sv | 30 +++
 rtl/imm_gen_stage.sv | 171 +++++++++++++++++
 tb/tb_imm_gen_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate-generation stage.
// Opcodes, extender op codes and FSM state encoding.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef enum logic [4:0] {
    EXT_NONE  = 5'd0,
    EXT_ITYPE = 5'd1,
    EXT_STYPE = 5'd2,
    EXT_BTYPE = 5'd3,
    EXT_UTYPE = 5'd4,
    EXT_JTYPE = 5'd5,
    EXT_SHAMT = 5'd6
  } ext_op_e;

`ifdef IMM_GEN_SKID_EN
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/imm_gen_ext.sv
// Combinational immediate extender.
// Ports: op_i (ext op), fields_i (instr[31:7]), imm_o (32-bit immediate).
module imm_ext
  import imm_gen_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [24:0] fields_i,
  output logic [31:0] imm_o
);

  // Rebuild a full-width word so field slices read like the ISA manual.
  logic [31:0] w;
  assign w = {fields_i, 7'b0};

  always_comb begin
    imm_o = '0;
    case (op_i)
      EXT_ITYPE: imm_o = {{20{w[31]}}, w[31:20]};
      EXT_STYPE: imm_o = {{20{w[31]}}, w[31:25], w[11:7]};
      EXT_BTYPE: imm_o = {{19{w[31]}}, w[31], w[7],
                          w[30:25], w[11:8], 1'b0};
      EXT_UTYPE: imm_o = {w[31:12], 12'b0};
      EXT_JTYPE: imm_o = {{11{w[31]}}, w[31], w[19:12],
                          w[20], w[30:21], 1'b0};
      EXT_SHAMT: imm_o = {27'b0, w[24:20]};
      default:   imm_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage with valid/ready on both sides.
// Ports: clk, rst, flush, in_* (instr/pc), out_* (imm/op/pc/target/illegal).
// IMM_GEN_SKID_EN adds a one-entry skid buffer with a registered in_ready.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_ext_op,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       sh;
  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign sh  = (f3 == F3_SLLI) || (f3 == F3_SRXI);

  ext_op_e op_d;
  logic    ill_d;

  always_comb begin
    op_d  = EXT_NONE;
    ill_d = 1'b0;
    unique case (1'b1)
      (opc == OPC_LOAD),
      (opc == OPC_JALR):          op_d = EXT_ITYPE;
      (opc == OPC_OPIMM) && !sh:  op_d = EXT_ITYPE;
      (opc == OPC_OPIMM) && sh:   op_d = EXT_SHAMT;
      (opc == OPC_STORE):         op_d = EXT_STYPE;
      (opc == OPC_BRANCH):        op_d = EXT_BTYPE;
      (opc == OPC_LUI),
      (opc == OPC_AUIPC):         op_d = EXT_UTYPE;
      (opc == OPC_JAL):           op_d = EXT_JTYPE;
      default:                    ill_d = 1'b1;
    endcase
  end

  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] tgt_d;

  imm_ext u_ext (
    .op_i     (op_d),
    .fields_i (in_instr[31:7]),
    .imm_o    (imm_d)
  );

  // Target is formed before the register, off the out_ready path.
  assign tgt_d = in_pc + imm_d;

  state_e          state_q;
  logic            valid_q;
  logic [XLEN-1:0] imm_q, pc_q, tgt_q;
  ext_op_e         op_q;
  logic            ill_q;

  logic acc, pop;
  assign pop = valid_q && out_ready;
  assign acc = in_valid && in_ready;

`ifdef IMM_GEN_SKID_EN
  logic            rdy_q;
  logic [XLEN-1:0] sk_imm_q, sk_pc_q, sk_tgt_q;
  ext_op_e         sk_op_q;
  logic            sk_ill_q;
  assign in_ready = rdy_q;
`else
  assign in_ready = !valid_q || out_ready;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      valid_q <= 1'b0;
      imm_q   <= '0;
      pc_q    <= '0;
      tgt_q   <= '0;
      op_q    <= EXT_NONE;
      ill_q   <= 1'b0;
`ifdef IMM_GEN_SKID_EN
      rdy_q    <= 1'b1;
      sk_imm_q <= '0;
      sk_pc_q  <= '0;
      sk_tgt_q <= '0;
      sk_op_q  <= EXT_NONE;
      sk_ill_q <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= S_EMPTY;
      valid_q <= 1'b0;
`ifdef IMM_GEN_SKID_EN
      rdy_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (acc) begin
            imm_q   <= imm_d;
            pc_q    <= in_pc;
            tgt_q   <= tgt_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            valid_q <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
`ifdef IMM_GEN_SKID_EN
          if (acc && !pop) begin
            sk_imm_q <= imm_d;
            sk_pc_q  <= in_pc;
            sk_tgt_q <= tgt_d;
            sk_op_q  <= op_d;
            sk_ill_q <= ill_d;
            rdy_q    <= 1'b0;
            state_q  <= S_FULL;
          end else
`endif
          if (acc) begin
            imm_q <= imm_d;
            pc_q  <= in_pc;
            tgt_q <= tgt_d;
            op_q  <= op_d;
            ill_q <= ill_d;
          end else if (pop) begin
            valid_q <= 1'b0;
            state_q <= S_EMPTY;
          end
        end
`ifdef IMM_GEN_SKID_EN
        S_FULL: begin
          if (pop) begin
            imm_q   <= sk_imm_q;
            pc_q    <= sk_pc_q;
            tgt_q   <= sk_tgt_q;
            op_q    <= sk_op_q;
            ill_q   <= sk_ill_q;
            rdy_q   <= 1'b1;
            state_q <= S_BUSY;
          end
        end
`endif
        default: begin
          valid_q <= 1'b0;
          state_q <= S_EMPTY;
        end
      endcase
    end
  end

  assign out_valid   = valid_q;
  assign out_imm     = imm_q;
  assign out_ext_op  = op_q;
  assign out_pc      = pc_q;
  assign out_target  = tgt_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed vector bench for imm_gen_stage.
// Covers decode table, back-pressure, flush and mid-run reset.
module tb_imm_gen_stage;

  logic        clk, rst, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_imm, out_pc, out_target;
  logic [4:0]  out_ext_op;
  logic        out_illegal;

  imm_gen_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_ext_op  (out_ext_op),
    .out_pc      (out_pc),
    .out_target  (out_target),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", nm, got, exp);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [4:0]  op;
    logic        ill;
  } vec_t;

  vec_t v[13];
  logic [31:0] bpi[4];
  logic [31:0] rcv[$];
  int nacc, seen, exp_acc;
  logic took;

  initial begin
    v[0]  = '{32'hFFF00093, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b0};
    v[1]  = '{32'hFE000EE3, 32'h100,      32'hFFFFFFFC, 32'h000000FC, 5'd3, 1'b0};
    v[2]  = '{32'h0010006F, 32'h1000,     32'h00000800, 32'h00001800, 5'd5, 1'b0};
    v[3]  = '{32'h123450B7, 32'h1004,     32'h12345000, 32'h12346004, 5'd4, 1'b0};
    v[4]  = '{32'h00509093, 32'h1008,     32'h00000005, 32'h0000100D, 5'd6, 1'b0};
    v[5]  = '{32'h00000000, 32'h100C,     32'h00000000, 32'h0000100C, 5'd0, 1'b1};
    v[6]  = '{32'hFE20AC23, 32'h2000,     32'hFFFFFFF8, 32'h00001FF8, 5'd2, 1'b0};
    v[7]  = '{32'h80000097, 32'h10,       32'h80000000, 32'h80000010, 5'd4, 1'b0};
    v[8]  = '{32'h7FF02083, 32'hFFFFF000, 32'h000007FF, 32'hFFFFF7FF, 5'd1, 1'b0};
    v[9]  = '{32'h41F0D093, 32'h0,        32'h0000001F, 32'h0000001F, 5'd6, 1'b0};
    v[10] = '{32'h00008067, 32'h40,       32'h00000000, 32'h00000040, 5'd1, 1'b0};
    v[11] = '{32'hFFFFF06F, 32'h8,        32'hFFFFFFFE, 32'h00000006, 5'd5, 1'b0};
    v[12] = '{32'hFFFFFFFF, 32'h20,       32'h00000000, 32'h00000020, 5'd0, 1'b1};
    for (int k = 0; k < 4; k++)
      bpi[k] = {12'(k + 10), 5'd0, 3'd0, 5'd1, 7'h13};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ill", {31'b0, out_illegal}, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_tgt", out_target, 32'd0);
    chk("rst_op", {27'b0, out_ext_op}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back stream through the decode table.
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_instr = v[i].instr;
      in_pc    = v[i].pc;
      #1;
      chk($sformatf("v%0d_ready", i), {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("v%0d_imm", i), out_imm, v[i].imm);
      chk($sformatf("v%0d_op", i), {27'b0, out_ext_op}, {27'b0, v[i].op});
      chk($sformatf("v%0d_pc", i), out_pc, v[i].pc);
      chk($sformatf("v%0d_tgt", i), out_target, v[i].tgt);
      chk($sformatf("v%0d_ill", i), {31'b0, out_illegal}, {31'b0, v[i].ill});
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // Back-pressure: 3 stalled cycles, then release.
`ifdef IMM_GEN_SKID_EN
    exp_acc = 2;
`else
    exp_acc = 1;
`endif
    nacc = 0;
    out_ready = 1'b0;
    repeat (3) begin
      in_valid = 1'b1;
      in_instr = bpi[nacc];
      in_pc    = 32'(nacc * 4);
      #1;
      took = in_ready;
      @(posedge clk);
      if (took) nacc++;
      #1;
    end
    chk("bp_accepted", 32'(nacc), 32'(exp_acc));
    chk("bp_ready_low", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_imm", out_imm, 32'd10);
    chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && rcv.size() < 4; c++) begin
      if (nacc < 4) begin
        in_valid = 1'b1;
        in_instr = bpi[nacc];
        in_pc    = 32'(nacc * 4);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      took = in_valid && in_ready;
      if (out_valid) rcv.push_back(out_imm);
      @(posedge clk);
      if (took) nacc++;
      #1;
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(rcv.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < rcv.size())
        chk($sformatf("bp_order%0d", k), rcv[k], 32'(k + 10));
    #1;
    chk("bp_no_dup", {31'b0, out_valid}, 32'd0);

    // Flush with stage loaded (FULL when the skid buffer exists).
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1;
      in_instr = bpi[j];
      in_pc    = 32'h300;
      @(posedge clk);
      #1;
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = v[3].instr;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    seen = 0;
    repeat (3) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    chk("fl_nothing", 32'(seen), 32'd0);
    in_valid = 1'b1;
    in_instr = v[2].instr;
    in_pc    = v[2].pc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("fl_next_valid", {31'b0, out_valid}, 32'd1);
    chk("fl_next_imm", out_imm, v[2].imm);
    chk("fl_next_tgt", out_target, v[2].tgt);

    // Reset with entries in flight.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1;
      in_instr = bpi[j];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mr_imm", out_imm, 32'd0);
    chk("mr_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    repeat (3) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    chk("mr_nothing", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
